// File: rtl/mips32_fetch_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips32_fetch_queue_if                                                      |
// | Instruction-memory read port and ID-stage handshake of the fetch queue.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface mips32_fetch_queue_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 10
);
  logic                     imem_req;
  logic [AW-1:0]            imem_addr;
  logic [31:0]              imem_rdata;
  logic                     redirect;
  logic [31:0]              redirect_pc;
  logic                     id_valid;
  logic                     id_ready;
  logic [31:0]              id_ir;
  logic [31:0]              id_npc;
  logic                     stopped;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata,
    input  redirect, redirect_pc,
    output id_valid, id_ir, id_npc,
    input  id_ready,
    output stopped, count
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata,
    output redirect, redirect_pc,
    input  id_valid, id_ir, id_npc,
    output id_ready,
    input  stopped, count
  );
endinterface
`default_nettype wire

// File: rtl/mips32_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips32_fetch_queue                                                         |
// | MIPS32 fetch front end: PC, 1-cycle imem read, FIFO of {IR, NPC} to ID.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mips32_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 10,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic                 clk1,
  input  logic                 rst,
  mips32_fetch_queue_if.master bus
);
  localparam int              PW       = $clog2(DEPTH);
  localparam int              CW       = PW + 1;
  localparam logic [CW-1:0]   c_depth  = CW'(DEPTH);
  localparam logic [5:0]      c_hlt_op = 6'h3F;

  typedef enum logic [0:0] {
    ST_FETCH   = 1'b0,
    ST_STOPPED = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          inflight_q, inflight_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   ir_mem_q  [DEPTH];
  logic [31:0]   npc_mem_q [DEPTH];

  logic          w_hlt_resp;
  logic          w_req;
  logic          w_push;
  logic          w_pop;
  logic [CW:0]   w_occ;

  // Occupancy counts the in-flight word so a response always finds a free slot.
  assign w_hlt_resp = inflight_q && (bus.imem_rdata[31:26] == c_hlt_op);
  assign w_occ      = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign w_req      = !rst && (state_q == ST_FETCH) && !bus.redirect &&
                      (w_occ < {1'b0, c_depth}) && !w_hlt_resp;
  assign w_push     = inflight_q && !bus.redirect;
  assign w_pop      = (count_q != '0) && bus.id_ready && !bus.redirect;

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = pc_q[AW-1:0];
  assign bus.id_valid  = (count_q != '0);
  assign bus.id_ir     = ir_mem_q[rd_ptr_q];
  assign bus.id_npc    = npc_mem_q[rd_ptr_q];
  assign bus.stopped   = (state_q == ST_STOPPED) && (count_q == '0);
  assign bus.count     = count_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = w_req;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (bus.redirect) begin
      state_d    = ST_FETCH;
      pc_d       = bus.redirect_pc;
      inflight_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (w_req) begin
        pc_d     = pc_q + 32'd1;
        req_pc_d = pc_q;
      end
      if (w_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if ((state_q == ST_FETCH) && w_push && w_hlt_resp) state_d = ST_STOPPED;
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ir_mem_q[i]  <= '0;
        npc_mem_q[i] <= '0;
      end
    end else if (w_push) begin
      ir_mem_q[wr_ptr_q]  <= bus.imem_rdata;
      npc_mem_q[wr_ptr_q] <= req_pc_q + 32'd1;
    end
  end

  a_no_push_full: assert property (@(posedge clk1) disable iff (rst)
    !(w_push && (count_q == c_depth)));
  a_no_pop_empty: assert property (@(posedge clk1) disable iff (rst)
    !(w_pop && (count_q == '0)));

endmodule
`default_nettype wire

// File: tb/tb_mips32_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mips32_fetch_queue                                                      |
// | Scenario and randomized checks of the fetch queue against a queue model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mips32_fetch_queue;
  localparam int          DEPTH      = 4;
  localparam int          AW         = 10;
  localparam int          CW         = $clog2(DEPTH) + 1;
  localparam logic [5:0]  c_hlt_op   = 6'h3F;
  localparam logic [31:0] c_hlt_word = 32'hFC00_0000;

  logic clk1 = 1'b0;
  logic rst;
  always #5 clk1 = ~clk1;

  mips32_fetch_queue_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

  mips32_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(32'd0)) dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus)
  );

  logic [31:0] imem [1024];
  always @(posedge clk1) if (bus.imem_req === 1'b1) bus.imem_rdata <= imem[bus.imem_addr];

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } entry_t;

  // Reference model: program-order queue of expected entries plus fetch PC.
  entry_t      m_q[$];
  logic        m_inflight = 1'b0;
  logic        m_stopped  = 1'b0;
  logic        m_init     = 1'b0;
  logic [31:0] m_pc       = 32'd0;
  logic [31:0] m_req_pc   = 32'd0;

  logic          s_req, s_valid, s_stopped;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_ir, s_npc;
  logic [CW-1:0] s_count;

  int n_vec = 0;
  int n_err = 0;

  task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
    logic          e_req, e_valid, e_stopped, m_hlt;
    logic [AW-1:0] e_addr;
    logic [CW-1:0] e_count;
    logic [31:0]   resp;
    entry_t        ent;
    rst = r; bus.redirect = rd; bus.redirect_pc = rpc; bus.id_ready = rdy;
    #1;
    s_req = bus.imem_req;   s_addr  = bus.imem_addr; s_valid   = bus.id_valid;
    s_ir  = bus.id_ir;      s_npc   = bus.id_npc;    s_count   = bus.count;
    s_stopped = bus.stopped;
    resp      = imem[m_req_pc[AW-1:0]];
    m_hlt     = m_inflight && (resp[31:26] == c_hlt_op);
    e_req     = !r && !m_stopped && !rd && ((m_q.size() + int'(m_inflight)) < DEPTH) && !m_hlt;
    e_addr    = m_pc[AW-1:0];
    e_valid   = (m_q.size() != 0);
    e_count   = CW'(m_q.size());
    e_stopped = m_stopped && (m_q.size() == 0);
    if (m_init) begin
      n_vec++;
      if (s_req !== e_req) begin n_err++; $display("FAIL sb_req t=%0t got %b want %b", $time, s_req, e_req); end
      if (e_req) begin
        n_vec++;
        if (s_addr !== e_addr) begin n_err++; $display("FAIL sb_addr t=%0t got %h want %h", $time, s_addr, e_addr); end
      end
      n_vec++;
      if (s_valid !== e_valid) begin n_err++; $display("FAIL sb_valid t=%0t got %b want %b", $time, s_valid, e_valid); end
      n_vec++;
      if (s_count !== e_count) begin n_err++; $display("FAIL sb_count t=%0t got %0d want %0d", $time, s_count, e_count); end
      n_vec++;
      if (s_stopped !== e_stopped) begin n_err++; $display("FAIL sb_stopped t=%0t got %b want %b", $time, s_stopped, e_stopped); end
      if (e_valid) begin
        n_vec++;
        if (s_ir !== m_q[0].ir) begin n_err++; $display("FAIL sb_ir t=%0t got %h want %h", $time, s_ir, m_q[0].ir); end
        n_vec++;
        if (s_npc !== m_q[0].npc) begin n_err++; $display("FAIL sb_npc t=%0t got %h want %h", $time, s_npc, m_q[0].npc); end
      end
    end
    if (r) begin
      m_q.delete(); m_inflight = 1'b0; m_stopped = 1'b0; m_pc = 32'd0; m_req_pc = 32'd0; m_init = 1'b1;
    end else if (rd) begin
      m_q.delete(); m_inflight = 1'b0; m_stopped = 1'b0; m_pc = rpc;
    end else begin
      if (e_valid && rdy) void'(m_q.pop_front());
      if (m_inflight) begin
        ent.ir = resp; ent.npc = m_req_pc + 32'd1;
        m_q.push_back(ent);
        if (m_hlt) m_stopped = 1'b1;
      end
      if (e_req) begin m_req_pc = m_pc; m_pc = m_pc + 32'd1; end
      m_inflight = e_req;
    end
    @(posedge clk1); #1;
  endtask

  task automatic load_linear();
    for (int a = 0; a < 1024; a++) imem[a] = 32'd100 + 32'(a);
  endtask

  task automatic test_reset();
    load_linear();
    step(1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    n_vec++;
    if ({s_req, s_valid, s_stopped} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", {s_req, s_valid, s_stopped}); end
    n_vec++;
    if (s_count !== '0) begin n_err++; $display("FAIL reset_count got %0d want 0", s_count); end
    n_vec++;
    if ({s_ir, s_npc} !== 64'd0) begin n_err++; $display("FAIL reset_head got %h/%h want 0/0", s_ir, s_npc); end
  endtask

  task automatic test_stream();
    load_linear();
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    n_vec++;
    if ({s_req, s_addr} !== {1'b1, 10'd0}) begin n_err++; $display("FAIL stream_first_req got %b/%h want 1/000", s_req, s_addr); end
    step(1'b0, 1'b0, 32'd0, 1'b1);
    n_vec++;
    if (s_valid !== 1'b0) begin n_err++; $display("FAIL stream_lat1 got %b want 0", s_valid); end
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b0, 32'd0, 1'b1);
      n_vec++;
      if ({s_valid, s_ir, s_npc} !== {1'b1, 32'd100 + 32'(k), 32'(k + 1)}) begin
        n_err++; $display("FAIL stream_word%0d got %b/%0d/%0d want 1/%0d/%0d", k, s_valid, s_ir, s_npc, 100 + k, k + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    int nreq, k, first;
    load_linear();
    step(1'b1, 1'b0, 32'd0, 1'b0);
    nreq = 0;
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 1'b0, 32'd0, 1'b0);
      if (s_req === 1'b1) begin
        n_vec++;
        if (s_addr !== 10'(nreq)) begin n_err++; $display("FAIL bp_addr got %0d want %0d", s_addr, nreq); end
        nreq++;
      end
    end
    n_vec++;
    if (nreq != 4) begin n_err++; $display("FAIL bp_nreq got %0d want 4", nreq); end
    n_vec++;
    if ({s_req, s_count} !== {1'b0, 3'd4}) begin n_err++; $display("FAIL bp_full got %b/%0d want 0/4", s_req, s_count); end
    k = 0; first = -1;
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 1'b0, 32'd0, 1'b1);
      if (s_valid === 1'b1) begin
        n_vec++;
        if (s_ir !== 32'd100 + 32'(k)) begin n_err++; $display("FAIL bp_order got %0d want %0d", s_ir, 100 + k); end
        k++;
      end
      if ((s_req === 1'b1) && (first < 0)) first = int'(s_addr);
    end
    n_vec++;
    if (first != 4) begin n_err++; $display("FAIL bp_resume_addr got %0d want 4", first); end
  endtask

  task automatic test_redirect();
    load_linear();
    step(1'b1, 1'b0, 32'd0, 1'b0);
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 32'h40, 1'b1);
    n_vec++;
    if ({s_req, s_count} !== {1'b0, 3'd3}) begin n_err++; $display("FAIL redir_cycle got %b/%0d want 0/3", s_req, s_count); end
    step(1'b0, 1'b0, 32'd0, 1'b1);
    n_vec++;
    if ({s_count, s_valid, s_req, s_addr} !== {3'd0, 1'b0, 1'b1, 10'h40}) begin
      n_err++; $display("FAIL redir_flush got cnt%0d v%b r%b a%h want cnt0 v0 r1 a040", s_count, s_valid, s_req, s_addr);
    end
    step(1'b0, 1'b0, 32'd0, 1'b1);
    n_vec++;
    if (s_valid !== 1'b0) begin n_err++; $display("FAIL redir_stale got valid %b ir %0d want 0", s_valid, s_ir); end
    step(1'b0, 1'b0, 32'd0, 1'b1);
    n_vec++;
    if ({s_valid, s_ir, s_npc} !== {1'b1, 32'd164, 32'h41}) begin
      n_err++; $display("FAIL redir_target got %b/%0d/%h want 1/164/41", s_valid, s_ir, s_npc);
    end
  endtask

  task automatic test_hlt();
    int  k;
    logic bad_req;
    load_linear();
    imem[5] = c_hlt_word;
    step(1'b1, 1'b0, 32'd0, 1'b1);
    k = 0; bad_req = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 1'b0, 32'd0, 1'b1);
      if ((s_req === 1'b1) && (s_addr >= 10'd6)) bad_req = 1'b1;
      if (s_valid === 1'b1) begin
        n_vec++;
        if (s_ir !== ((k == 5) ? c_hlt_word : 32'd100 + 32'(k))) begin n_err++; $display("FAIL hlt_word%0d got %h", k, s_ir); end
        n_vec++;
        if (s_stopped !== 1'b0) begin n_err++; $display("FAIL hlt_stop_early got %b want 0", s_stopped); end
        k++;
      end
    end
    n_vec++;
    if (k != 6) begin n_err++; $display("FAIL hlt_ndeliv got %0d want 6", k); end
    n_vec++;
    if (bad_req !== 1'b0) begin n_err++; $display("FAIL hlt_extra_req got %b want 0", bad_req); end
    n_vec++;
    if (s_stopped !== 1'b1) begin n_err++; $display("FAIL hlt_stopped got %b want 1", s_stopped); end
    step(1'b0, 1'b1, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    n_vec++;
    if ({s_stopped, s_req, s_addr} !== {1'b0, 1'b1, 10'd0}) begin
      n_err++; $display("FAIL hlt_restart got s%b r%b a%h want s0 r1 a000", s_stopped, s_req, s_addr);
    end
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic test_redirect_on_hlt();
    logic seen_hlt, seen_stop;
    int   first;
    load_linear();
    imem[5] = c_hlt_word;
    step(1'b1, 1'b0, 32'd0, 1'b1);
    for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b1, 32'h20, 1'b1);
    seen_hlt = 1'b0; seen_stop = 1'b0; first = -1;
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 1'b0, 32'd0, 1'b1);
      if (s_stopped === 1'b1) seen_stop = 1'b1;
      if ((s_valid === 1'b1) && (s_ir === c_hlt_word)) seen_hlt = 1'b1;
      if ((s_valid === 1'b1) && (first < 0)) first = int'(s_ir);
    end
    n_vec++;
    if ({seen_hlt, seen_stop} !== 2'b00) begin n_err++; $display("FAIL rhlt_discard got hlt%b stop%b want 00", seen_hlt, seen_stop); end
    n_vec++;
    if (first != 132) begin n_err++; $display("FAIL rhlt_target got %0d want 132", first); end
  endtask

  task automatic test_mid_reset();
    load_linear();
    step(1'b1, 1'b0, 32'd0, 1'b0);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    n_vec++;
    if (s_count !== 3'd2) begin n_err++; $display("FAIL mrst_precount got %0d want 2", s_count); end
    step(1'b0, 1'b0, 32'd0, 1'b1);
    n_vec++;
    if ({s_count, s_valid, s_req, s_addr} !== {3'd0, 1'b0, 1'b1, 10'd0}) begin
      n_err++; $display("FAIL mrst_clear got cnt%0d v%b r%b a%h want cnt0 v0 r1 a000", s_count, s_valid, s_req, s_addr);
    end
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    n_vec++;
    if ({s_valid, s_ir} !== {1'b1, 32'd100}) begin n_err++; $display("FAIL mrst_resume got %b/%0d want 1/100", s_valid, s_ir); end
  endtask

  task automatic test_random();
    logic [31:0] w, rpc;
    logic        r, rd, rdy;
    for (int a = 0; a < 1024; a++) begin
      w = $urandom;
      if (w[31:26] == c_hlt_op) w[31:26] = 6'd0;
      imem[a] = w;
    end
    for (int h = 0; h < 8; h++) imem[$urandom_range(0, 1023)] = c_hlt_word | ($urandom & 32'h03FF_FFFF);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      r   = ($urandom_range(0, 999) < 3);
      rd  = !r && ($urandom_range(0, 99) < (m_stopped ? 20 : 2));
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                        : 32'($urandom_range(0, 1023));
      rdy = ($urandom_range(0, 3) != 0);
      step(r, rd, rpc, rdy);
      n_vec++;
      if (s_count > 3'(DEPTH)) begin n_err++; $display("FAIL rnd_overflow got %0d want <=%0d", s_count, DEPTH); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.id_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_hlt();
    test_redirect_on_hlt();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
